nibble_serial_subtractor: RTL

- Multi-cycle 16-bit subtractor computing diff = a - b, one 4-bit carry-select slice per clock, least-significant nibble first.
- Subtraction is done as a + ~b + 1.
- Pairs with the existing combinational carry-select adders and reuses the dual-sum / mux-select nibble structure.
- Sits behind a valid/ready handshake so ALU control logic can issue operands and stall on the result.

---
 rtl/nibble_serial_subtractor_if.sv | 30 +++
 rtl/nibble_serial_subtractor.sv | 107 ++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// master = issuing ALU control, slave = subtractor.
interface nibble_serial_subtractor_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff,
    input  borrow, zero, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff,
    output borrow, zero, overflow
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b as a + ~b + 1, one carry-select nibble per clock,
// LSB nibble first, behind valid/ready handshakes.
module nibble_serial_subtractor #(
  parameter int NIBBLES = 4
) (
  input logic                        clk,
  input logic                        rst,
  nibble_serial_subtractor_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(NIBBLES);

  logic [1:0]    r_state;
  logic [W-1:0]  r_opa;
  logic [W-1:0]  r_opb_n;
  logic          r_b_msb;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_diff;
  logic          r_borrow;
  logic          r_zero;
  logic          r_ovf;

  logic [IW-1:0] w_pos;
  logic [IW+1:0] w_base;
  logic [3:0]    w_na;
  logic [3:0]    w_nb;
  logic [4:0]    w_sum0;
  logic [4:0]    w_sum1;
  logic [4:0]    w_sel;
  logic [W-1:0]  w_diff_next;

  // Index past the last slice only occurs on the
  // finishing cycle; clamp so the read stays in range.
  assign w_pos  = (r_idx < LAST) ? r_idx : '0;
  assign w_base = {w_pos, 2'b00};
  assign w_na   = r_opa[w_base +: 4];
  assign w_nb   = r_opb_n[w_base +: 4];
  assign w_sum0 = {1'b0, w_na} + {1'b0, w_nb};
  assign w_sum1 = {1'b0, w_na} + {1'b0, w_nb} + 5'd1;
  assign w_sel  = r_carry ? w_sum1 : w_sum0;

  // Current diff with the active slice replaced.
  always_comb begin
    w_diff_next = r_diff;
    w_diff_next[w_base +: 4] = w_sel[3:0];
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_borrow;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_ovf;

  // Control FSM, slice datapath and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_opa    <= '0;
      r_opb_n  <= '0;
      r_b_msb  <= 1'b0;
      r_carry  <= 1'b1;
      r_idx    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_opa   <= bus.a;
            r_opb_n <= ~bus.b;
            r_b_msb <= bus.b[W-1];
            r_carry <= 1'b1;
            r_idx   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_idx == LAST) begin
            r_borrow <= ~r_carry;
            r_zero   <= (r_diff == '0);
            r_ovf    <= (r_opa[W-1] != r_b_msb) &&
                        (r_diff[W-1] != r_opa[W-1]);
            r_state  <= S_DONE;
          end else begin
            r_diff  <= w_diff_next;
            r_carry <= w_sel[4];
            r_idx   <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
